// File: rtl/fp_mul_core.sv
// Iterative IEEE-754 single-precision multiplier: 24-cycle shift-add mantissa core,
// then normalize/special-case resolution. Fixed 26-cycle start-to-done latency.
module fp_mul_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        mul_enable,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] product,
  output logic        mul_done,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for mul_enable; product holds last result
  // MUL   | one shift-add step per cycle, 24 steps
  // NORM  | normalize, exponent, specials; register product
  // DONE  | mul_done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [47:0] r_acc;
  logic [23:0] r_mb;
  logic [4:0]  r_cnt;

  logic [23:0]       w_ma;
  logic [24:0]       w_sum;
  logic [7:0]        w_ea;
  logic [7:0]        w_eb;
  logic              w_sign;
  logic signed [9:0] w_exp;
  logic [22:0]       w_mant;
  logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [31:0]       w_result;

  assign w_ma  = {1'b1, r_a[22:0]};
  // Multiplier sits in r_mb, partial product accumulates in the upper half and shifts right.
  assign w_sum = {1'b0, r_acc[47:24]} + (r_mb[0] ? {1'b0, w_ma} : 25'd0);

  assign w_ea     = r_a[30:23];
  assign w_eb     = r_b[30:23];
  assign w_sign   = r_a[31] ^ r_b[31];
  assign w_a_nan  = (w_ea == 8'hFF) && (r_a[22:0] != 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (r_b[22:0] != 23'd0);
  assign w_a_inf  = (w_ea == 8'hFF) && (r_a[22:0] == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (r_b[22:0] == 23'd0);
  assign w_a_zero = (w_ea == 8'h00);
  assign w_b_zero = (w_eb == 8'h00);
  assign w_exp    = 10'(w_ea) + 10'(w_eb) - 10'd127 + 10'(r_acc[47]);
  assign w_mant   = r_acc[47] ? r_acc[46:24] : r_acc[45:23];

  always_comb begin
    w_result = {w_sign, w_exp[7:0], w_mant};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      w_result = 32'h7FC0_0000;
    else if (w_a_inf || w_b_inf)
      w_result = {w_sign, 8'hFF, 23'd0};
    else if (w_a_zero || w_b_zero)
      w_result = {w_sign, 31'd0};
    else if (w_exp >= 10'sd255)
      w_result = {w_sign, 8'hFF, 23'd0};
    else if (w_exp <= 10'sd0)
      w_result = {w_sign, 31'd0};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_acc    <= 48'd0;
      r_mb     <= 24'd0;
      r_cnt    <= 5'd0;
      product  <= 32'd0;
      mul_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          mul_done <= 1'b0;
          if (mul_enable) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= 48'd0;
            r_mb    <= {1'b1, b[22:0]};
            r_cnt   <= 5'd23;
            busy    <= 1'b1;
            r_state <= MUL;
          end
        end
        MUL: begin
          r_acc <= {w_sum, r_acc[23:1]};
          r_mb  <= {1'b0, r_mb[23:1]};
          if (r_cnt == 5'd0) r_state <= NORM;
          else               r_cnt   <= r_cnt - 5'd1;
        end
        NORM: begin
          product  <= w_result;
          mul_done <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          mul_done <= 1'b0;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_core.sv
// Scoreboard bench for fp_mul_core: expected products are queued at start and
// checked when mul_done fires; latency, busy width, abort and restart are checked inline.
module tb_fp_mul_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mul_enable = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] product;
  logic        mul_done;
  logic        busy;

  int total = 0;
  int bad = 0;
  logic [31:0] sb_q[$];
  logic        prev_done = 1'b0;

  fp_mul_core dut (
    .clk(clk), .reset(reset), .mul_enable(mul_enable), .a(a), .b(b),
    .product(product), .mul_done(mul_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    int          ex, ey, e;
    logic [63:0] p;
    logic [22:0] m;
    logic        xn, yn, xi, yi, xz, yz;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xz = (ex == 0);
    yz = (ey == 0);
    if (xn || yn || (xi && yz) || (yi && xz)) return 32'h7FC0_0000;
    if (xi || yi) return {s, 8'hFF, 23'd0};
    if (xz || yz) return {s, 31'd0};
    p = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
    e = ex + ey - 127;
    if (p[47]) begin e++; m = p[46:24]; end
    else m = p[45:23];
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], m};
  endfunction

  // Scoreboard consumer: every mul_done pops one expected product.
  always @(posedge clk) begin
    #1;
    if (mul_done) begin
      chk("no_back_to_back_done", 32'(prev_done), 32'd0);
      if (sb_q.size() == 0) chk("spurious_done", 32'(mul_done), 32'd0);
      else chk("product", product, sb_q.pop_front());
    end
    prev_done = mul_done;
  end

  // Drives one start pulse; optionally re-pulses with new operands at cycle dist_cyc.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] expv, input int dist_cyc);
    int n;
    int busy_n;
    @(negedge clk);
    a = ia; b = ib; mul_enable = 1'b1;
    sb_q.push_back(expv);
    @(posedge clk); #1;
    mul_enable = 1'b0;
    n = 1;
    busy_n = busy ? 1 : 0;
    while (!mul_done && n < 40) begin
      if (n == dist_cyc) begin
        a = 32'h4120_0000; b = 32'h4120_0000; mul_enable = 1'b1;
      end else if (n == dist_cyc + 1) begin
        mul_enable = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (busy) busy_n++;
    end
    chk("latency", 32'(n), 32'd26);
    chk("busy_cycles", 32'(busy_n), 32'd26);
    @(posedge clk); #1;
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_width", 32'(mul_done), 32'd0);
    if (dist_cyc > 0) begin
      for (int i = 0; i < 30; i++) @(posedge clk);
      chk("no_restart_pending", 32'(sb_q.size()), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    int done_cyc[$];
    int cyc;

    #12;
    chk("rst_product", product, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(mul_done), 32'd0);
    @(negedge clk) reset = 1'b1;

    run_op(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 0);
    run_op(32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 0);
    run_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 0);
    run_op(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 0);
    run_op(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 0);
    run_op(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 0);
    run_op(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 0);
    run_op(32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 0);
    run_op(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 0);
    run_op(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 0);
    run_op(32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000, 0);
    run_op(32'h0000_1234, 32'h4000_0000, 32'h0000_0000, 0);
    run_op(32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 0);
    run_op(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 10);

    for (int i = 0; i < 10; i++) begin
      ra = $urandom();
      rb = $urandom();
      if (i < 6) begin
        ra[30:23] = 8'(100 + $urandom_range(0, 54));
        rb[30:23] = 8'(100 + $urandom_range(0, 54));
      end
      run_op(ra, rb, ref_mul(ra, rb), 0);
    end

    // Abort mid-operation with reset.
    @(negedge clk);
    a = 32'h40A0_0000; b = 32'h40A0_0000; mul_enable = 1'b1;
    sb_q.push_back(32'h41C8_0000);
    @(posedge clk); #1;
    mul_enable = 1'b0;
    for (int n = 1; n < 12; n++) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    chk("abort_product", product, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(mul_done), 32'd0);
    sb_q.delete();
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 30; i++) @(posedge clk);
    run_op(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 0);

    // Continuous mul_enable: back-to-back operations, 27-cycle cadence.
    @(negedge clk);
    a = 32'h4000_0000; b = 32'h4040_0000; mul_enable = 1'b1;
    for (int i = 0; i < 3; i++) sb_q.push_back(32'h40C0_0000);
    cyc = 0;
    while (done_cyc.size() < 3 && cyc < 120) begin
      @(posedge clk); #1;
      cyc++;
      if (mul_done) begin
        done_cyc.push_back(cyc);
        if (done_cyc.size() == 3) mul_enable = 1'b0;
      end
    end
    chk("hold_done_count", 32'(done_cyc.size()), 32'd3);
    if (done_cyc.size() == 3) begin
      chk("hold_period_1", 32'(done_cyc[1] - done_cyc[0]), 32'd27);
      chk("hold_period_2", 32'(done_cyc[2] - done_cyc[1]), 32'd27);
    end
    for (int i = 0; i < 30; i++) @(posedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_mul_core.md
FP_MUL_CORE -- requirements
Module: fp_mul_core

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 SHALL provide port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port: reset  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port: mul_enable  input  1  start request from controller.
REQ-005 SHALL provide port: a  input  32  IEEE-754 single operand A, sampled at accepted start.
REQ-006 SHALL provide port: b  input  32  IEEE-754 single operand B, sampled at accepted start.
REQ-007 SHALL provide port: product  output  32  result, held stable from mul_done until the next accepted start.
REQ-008 SHALL provide port: mul_done  output  1  one-cycle completion pulse.
REQ-009 SHALL provide port: busy  output  1  high from the accepted start edge until mul_done deasserts.

Function
REQ-010 SHALL implement FSM states IDLE, MUL, NORM, DONE.
REQ-011 In IDLE with mul_enable=1 at a rising edge, SHALL capture a and b, clear the accumulator, load 5-bit counter=23, and go to MUL.
REQ-012 In MUL, SHALL perform one shift-add step of the 24x24 mantissa multiply per cycle, with hidden 1 prepended; after counter==0 the step goes to NORM (24 MUL cycles).
REQ-013 In NORM, SHALL normalize, compute the exponent, resolve special cases, register product, and go to DONE.
REQ-014 In DONE, SHALL drive mul_done=1 for exactly one cycle, then return to IDLE.
REQ-015 Latency SHALL be fixed: mul_done high in the 26th cycle after the capture edge, for every operand class including specials.
REQ-016 mul_enable SHALL be ignored while busy=1; a start is accepted only in IDLE.
REQ-017 mul_enable held high through DONE SHALL start a new operation on the first edge in IDLE, with no back-to-back overlap.
REQ-018 Sign SHALL be a[31] XOR b[31], including zero and inf results.
REQ-019 Exponent SHALL be computed as 10-bit signed ea+eb-127, +1 when product bit 47 is set.
REQ-020 Mantissa SHALL be taken from bits 46:24 if bit 47 is set, else bits 45:23, truncating (round toward zero).
REQ-021 Exponent >=255 SHALL give signed infinity (exp 0xFF, mantissa 0).
REQ-022 Exponent <=0 SHALL give signed zero; no denormal outputs.
REQ-023 An operand with exp=0 (zero or denormal) SHALL be treated as zero (flush-to-zero).
REQ-024 NaN on either input, or inf x zero, SHALL give canonical NaN 0x7FC00000.
REQ-025 inf x finite nonzero SHALL give signed infinity.
REQ-026 Operand changes on a/b after capture SHALL NOT affect the result in progress.

Reset
REQ-027 reset=0 SHALL immediately force: state IDLE, product=0x00000000, mul_done=0, busy=0, counter=0, accumulator=0.
REQ-028 Reset asserted mid-operation SHALL abort without a mul_done pulse.
REQ-029 After reset deasserts, the first mul_enable SHALL start a clean operation.

Verification
REQ-030 a=0x3FC00000, b=0x40000000, pulse mul_enable -> product=0x40400000, mul_done 26 cycles after capture.
REQ-031 a=0xC0000000, b=0x40400000 -> product=0xC0C00000; busy high for 26 cycles.
REQ-032 a=0x7F800000, b=0x00000000 -> 0x7FC00000; a=0x7F000000, b=0x7F000000 -> 0x7F800000; a=0x00800000, b=0x00800000 -> 0x00000000.
REQ-033 Start 1.5x2.0; re-pulse mul_enable and change a and b at cycle 10 -> no restart, product=0x40400000, single mul_done.
REQ-034 Start an operation, assert reset at cycle 12 -> outputs zero immediately, no mul_done; after release, 2.0x2.0 -> 0x40800000.
REQ-035 Hold mul_enable high continuously with fixed operands -> mul_done pulses every 27 cycles, never two consecutive cycles.
